// File: rtl/troco_ctrl.sv
// Change dispenser controller: greedy 100c/50c/25c plan, one coin ejected per ack.
// Latency: start -> CHECK next cycle; empty plan -> done two cycles after start.
// Backpressure: EJECT holds eject_req until eject_ack; optional timeout via TROCO_TIMEOUT_EN.
module troco_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  valor_troco,
    input  logic [23:0] moedas_carteira,
    input  logic        eject_ack,
    output logic        eject_req,
    output logic [1:0]  eject_sel,
    output logic        busy,
    output logic        done,
    output logic        erro,
    output logic [23:0] moedas_troco,
    output logic [7:0]  resto
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_EJECT, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t      state_q;
    logic [7:0]  val_q, inv100_q, inv50_q, inv25_q;
    logic [7:0]  n100_q, n50_q, n25_q;
    logic        eject_req_q, busy_q, done_q, erro_q;
    logic [1:0]  eject_sel_q;
    logic [23:0] moedas_q;
    logic [7:0]  resto_q;

    // Greedy plan from the captured amount/inventory; only consumed in CHECK.
    logic [7:0] q100, q50, q25, r1, r2;
    logic [7:0] n100_d, n50_d, n25_d, resto_d;

`ifdef TROCO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
`endif

    // Largest denomination still owed; 00 when nothing remains.
    function automatic logic [1:0] pick(input logic [7:0] a100, input logic [7:0] a50,
                                        input logic [7:0] a25);
        if (a100 != 8'd0)     return 2'b11;
        else if (a50 != 8'd0) return 2'b10;
        else if (a25 != 8'd0) return 2'b01;
        else                  return 2'b00;
    endfunction

    // Plan computation: each step never exceeds inventory or the remaining amount.
    always_comb begin
        q100    = val_q / 8'd100;
        n100_d  = (inv100_q < q100) ? inv100_q : q100;
        r1      = val_q - n100_d * 8'd100;
        q50     = r1 / 8'd50;
        n50_d   = (inv50_q < q50) ? inv50_q : q50;
        r2      = r1 - n50_d * 8'd50;
        q25     = r2 / 8'd25;
        n25_d   = (inv25_q < q25) ? inv25_q : q25;
        resto_d = r2 - n25_d * 8'd25;
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            val_q       <= 8'd0;
            inv100_q    <= 8'd0;
            inv50_q     <= 8'd0;
            inv25_q     <= 8'd0;
            n100_q      <= 8'd0;
            n50_q       <= 8'd0;
            n25_q       <= 8'd0;
            eject_req_q <= 1'b0;
            eject_sel_q <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            erro_q      <= 1'b0;
            moedas_q    <= 24'd0;
            resto_q     <= 8'd0;
`ifdef TROCO_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        val_q    <= valor_troco;
                        inv25_q  <= moedas_carteira[7:0];
                        inv50_q  <= moedas_carteira[15:8];
                        inv100_q <= moedas_carteira[23:16];
                        moedas_q <= 24'd0;
                        resto_q  <= 8'd0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    resto_q <= resto_d;
                    n100_q  <= n100_d;
                    n50_q   <= n50_d;
                    n25_q   <= n25_d;
                    if (resto_d != 8'd0) begin
                        erro_q  <= 1'b1;
                        state_q <= S_FAIL;
                    end else if ((n100_d | n50_d | n25_d) == 8'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        eject_req_q <= 1'b1;
                        eject_sel_q <= pick(n100_d, n50_d, n25_d);
`ifdef TROCO_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= S_EJECT;
                    end
                end
                S_EJECT: begin
                    if (eject_ack) begin
                        case (eject_sel_q)
                            2'b11: begin
                                n100_q          <= n100_q - 8'd1;
                                moedas_q[23:16] <= moedas_q[23:16] + 8'd1;
                            end
                            2'b10: begin
                                n50_q          <= n50_q - 8'd1;
                                moedas_q[15:8] <= moedas_q[15:8] + 8'd1;
                            end
                            default: begin
                                n25_q         <= n25_q - 8'd1;
                                moedas_q[7:0] <= moedas_q[7:0] + 8'd1;
                            end
                        endcase
                        eject_req_q <= 1'b0;
                        eject_sel_q <= 2'b00;
`ifdef TROCO_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= S_GAP;
                    end
`ifdef TROCO_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Ejector stalled: abandon, keeping coins already paid out.
                        eject_req_q <= 1'b0;
                        eject_sel_q <= 2'b00;
                        erro_q      <= 1'b1;
                        state_q     <= S_FAIL;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if ((n100_q | n50_q | n25_q) == 8'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        eject_req_q <= 1'b1;
                        eject_sel_q <= pick(n100_q, n50_q, n25_q);
`ifdef TROCO_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= S_EJECT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    erro_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign eject_req    = eject_req_q;
    assign eject_sel    = eject_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign erro         = erro_q;
    assign moedas_troco = moedas_q;
    assign resto        = resto_q;

endmodule
